// File: rtl/enc_defines.sv
// Shared definitions for the fetch buffer: geometry and controller state encodings.
package enc_defines;

  localparam int FETCH_BUF_AW = 5;
  localparam int FETCH_BUF_DW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ram_1p_128x32.sv
// Single-port synchronous SRAM with low-active enables; read data is registered
// and held until the next read.
module fetch_ram_1p_128x32 #(
  parameter int Addr_Width = 5,
  parameter int Word_Width = 128
) (
  input  logic                  clk,
  input  logic                  cen_i,
  input  logic                  wen_i,
  input  logic                  oen_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Word_Width-1:0] data_i,
  output logic [Word_Width-1:0] data_o
);

  logic [Word_Width-1:0] mem_q [2**Addr_Width];
  logic [Word_Width-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (!cen_i) begin
      if (!wen_i) begin
        mem_q[addr_i] <= data_i;
      end else begin
        dout_q <= mem_q[addr_i];
      end
    end
  end

  assign data_o = oen_i ? '0 : dout_q;

endmodule

// File: rtl/fetch_ram_1p_ctrl.sv
// Fill-then-read controller for the fetch buffer SRAM: sequential fill from a
// valid/ready load stream, then one-cycle-latency random reads.
module fetch_ram_1p_ctrl
  import enc_defines::*;
#(
  parameter int Word_Width = FETCH_BUF_DW,
  parameter int Addr_Width = FETCH_BUF_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  wr_val_i,
  output logic                  wr_rdy_o,
  input  logic [Word_Width-1:0] wr_dat_i,
  output logic                  done_o,
  input  logic                  rd_req_i,
  input  logic [Addr_Width-1:0] rd_addr_i,
  output logic                  rd_rdy_o,
  output logic                  rd_val_o,
  output logic [Word_Width-1:0] rd_dat_o,
  output logic                  full_o
);

  fetch_state_e          state_q, state_d;
  logic [Addr_Width-1:0] wr_cnt_q, wr_cnt_d;
  logic                  rd_val_q, rd_val_d;
  logic                  done_q, done_d;
  logic                  write_acc, read_acc;
  logic                  sram_cen, sram_wen;
  logic [Addr_Width-1:0] sram_addr;

  // start_i always wins, so neither a beat nor a read is taken in its cycle
  always_comb begin
    write_acc = (state_q == FILL) && !start_i && wr_val_i;
    read_acc  = (state_q == READY) && !start_i && rd_req_i;
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    done_d    = 1'b0;
    rd_val_d  = read_acc;

    if (start_i) begin
      state_d  = FILL;
      wr_cnt_d = '0;
    end else if (write_acc) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == {Addr_Width{1'b1}}) begin
        state_d = READY;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_val_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_val_q <= rd_val_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    sram_cen  = !(write_acc || read_acc);
    sram_wen  = !write_acc;
    sram_addr = read_acc ? rd_addr_i : wr_cnt_q;
  end

  assign wr_rdy_o = (state_q == FILL) && !start_i;
  assign rd_rdy_o = read_acc;
  assign rd_val_o = rd_val_q;
  assign done_o   = done_q;
  assign full_o   = (state_q == READY);

  fetch_ram_1p_128x32 #(
    .Addr_Width(Addr_Width),
    .Word_Width(Word_Width)
  ) u_ram (
    .clk   (clk),
    .cen_i (sram_cen),
    .wen_i (sram_wen),
    .oen_i (1'b0),
    .addr_i(sram_addr),
    .data_i(wr_dat_i),
    .data_o(rd_dat_o)
  );

endmodule

// File: tb/tb_fetch_ram_1p_ctrl.sv
// Scoreboard bench for fetch_ram_1p_ctrl: stimulus pushes expected reads and
// done pulses, a negedge monitor pops and compares them.
module tb_fetch_ram_1p_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         wr_val_i;
  logic         wr_rdy_o;
  logic [127:0] wr_dat_i;
  logic         done_o;
  logic         rd_req_i;
  logic [4:0]   rd_addr_i;
  logic         rd_rdy_o;
  logic         rd_val_o;
  logic [127:0] rd_dat_o;
  logic         full_o;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } rd_exp_t;

  rd_exp_t      rd_q[$];
  int           done_q[$];
  logic [127:0] mem_model [32];
  int           tb_cnt;
  int           cyc = 0;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  fetch_ram_1p_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .wr_val_i (wr_val_i),
    .wr_rdy_o (wr_rdy_o),
    .wr_dat_i (wr_dat_i),
    .done_o   (done_o),
    .rd_req_i (rd_req_i),
    .rd_addr_i(rd_addr_i),
    .rd_rdy_o (rd_rdy_o),
    .rd_val_o (rd_val_o),
    .rd_dat_o (rd_dat_o),
    .full_o   (full_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  task automatic check_word(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [127:0] pat(input logic [7:0] tag, input int a);
    return {16{tag ^ 8'(a)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_val_o / done_o must match the oldest expectation
  always @(negedge clk) begin
    if (rd_val_o) begin
      if (rd_q.size() == 0) begin
        check_bit("rd_val_spurious", rd_val_o, 1'b0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check_int("rd_val_cycle", cyc, e.cyc);
        check_word("rd_data", rd_dat_o, e.data);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) check_bit("done_spurious", done_o, 1'b0);
      else check_int("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic do_start(input logic with_beat);
    start_i  = 1'b1;
    wr_val_i = with_beat;
    wr_dat_i = {16{8'hEE}};
    #1;
    check_bit("wr_rdy_on_start", wr_rdy_o, 1'b0);
    check_bit("rd_rdy_on_start", rd_rdy_o, 1'b0);
    tick();
    start_i  = 1'b0;
    wr_val_i = 1'b0;
    tb_cnt   = 0;
  endtask

  task automatic fill_beats(input int n, input logic [7:0] tag, input bit throttle);
    int  issued = 0;
    bit  v = 1'b1;
    while (issued < n) begin
      wr_val_i = throttle ? v : 1'b1;
      wr_dat_i = pat(tag, tb_cnt);
      #1;
      check_bit("wr_rdy_fill", wr_rdy_o, 1'b1);
      if (wr_val_i) begin
        mem_model[tb_cnt] = wr_dat_i;
        if (tb_cnt == 31) done_q.push_back(cyc + 1);
        tb_cnt = (tb_cnt + 1) % 32;
        issued++;
      end
      v = ~v;
      tick();
    end
    wr_val_i = 1'b0;
  endtask

  task automatic do_reads(input int addrs[$]);
    foreach (addrs[i]) begin
      rd_exp_t e;
      rd_req_i  = 1'b1;
      rd_addr_i = 5'(addrs[i]);
      #1;
      check_bit("rd_rdy_ready", rd_rdy_o, 1'b1);
      e.data = mem_model[addrs[i]];
      e.cyc  = cyc + 1;
      rd_q.push_back(e);
      tick();
    end
    rd_req_i = 1'b0;
    @(negedge clk);
    #1;
    check_int("rd_queue_drained", rd_q.size(), 0);
  endtask

  task automatic expect_ready();
    #1;
    check_bit("full_after_fill", full_o, 1'b1);
    check_bit("wr_rdy_after_fill", wr_rdy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; wr_val_i = 1'b0; wr_dat_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0; tb_cnt = 0;

    tick();
    check_bit("rst_wr_rdy", wr_rdy_o, 1'b0);
    check_bit("rst_rd_rdy", rd_rdy_o, 1'b0);
    check_bit("rst_done", done_o, 1'b0);
    check_bit("rst_rd_val", rd_val_o, 1'b0);
    check_bit("rst_full", full_o, 1'b0);
    tick();
    rst = 1'b0;

    // IDLE must refuse both reads and beats
    rd_req_i = 1'b1; wr_val_i = 1'b1;
    #1;
    check_bit("idle_rd_rdy", rd_rdy_o, 1'b0);
    check_bit("idle_wr_rdy", wr_rdy_o, 1'b0);
    tick();
    rd_req_i = 1'b0; wr_val_i = 1'b0;

    // Full-rate fill with address-replicated data, then random reads
    do_start(1'b0);
    fill_beats(32, 8'h00, 1'b0);
    expect_ready();
    do_reads('{0, 31, 7, 7, 16});

    // start_i colliding with a read in READY
    start_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = 5'd3;
    #1;
    check_bit("collide_rd_rdy", rd_rdy_o, 1'b0);
    tick();
    start_i = 1'b0;
    #1;
    check_bit("collide_full", full_o, 1'b0);
    check_bit("collide_wr_rdy", wr_rdy_o, 1'b1);
    check_bit("fill_rd_rdy", rd_rdy_o, 1'b0);
    rd_req_i = 1'b0;
    tb_cnt = 0;

    // Restart at beat 10, then a throttled complete fill
    fill_beats(10, 8'h55, 1'b0);
    do_start(1'b1);
    fill_beats(32, 8'hC3, 1'b1);
    expect_ready();
    do_reads('{0, 9, 10, 31});

    // Reset after 12 beats, then a normal fill
    do_start(1'b0);
    fill_beats(12, 8'h3C, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_bit("midrst_full", full_o, 1'b0);
    check_bit("midrst_wr_rdy", wr_rdy_o, 1'b0);
    check_bit("midrst_done", done_o, 1'b0);
    tick();
    do_start(1'b0);
    fill_beats(32, 8'h96, 1'b0);
    expect_ready();
    do_reads('{5, 11, 12, 30});

    tick();
    tick();
    check_int("done_queue_drained", done_q.size(), 0);
    check_int("rd_queue_final", rd_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
